// File: rtl/unified_cache_packet_arbiter.sv
// Round-robin arbiter feeding one registered packet slot into the unified cache.
// Optional port-id stamping on capture: define UNIFIED_CACHE_ARB_PORT_STAMP_EN.

`ifndef CPU_ADDR_LEN_IN_BITS
`define CPU_ADDR_LEN_IN_BITS 32
`endif
`ifndef UNIFIED_CACHE_BLOCK_SIZE_IN_BITS
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BITS 64
`endif
`ifndef UNIFIED_CACHE_PACKET_TYPE_WIDTH
`define UNIFIED_CACHE_PACKET_TYPE_WIDTH 4
`endif
`ifndef UNIFIED_CACHE_PACKET_BYTE_MASK_LEN
`define UNIFIED_CACHE_PACKET_BYTE_MASK_LEN 8
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
`define UNIFIED_CACHE_PACKET_PORT_ID_WIDTH 2
`endif
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 111
`endif

module unified_cache_packet_arbiter #(
    parameter int NUM_REQUESTER = 4,
    parameter int ADDR_LEN      = `CPU_ADDR_LEN_IN_BITS,
    parameter int DATA_LEN      = `UNIFIED_CACHE_BLOCK_SIZE_IN_BITS,
    parameter int TYPE_LEN      = `UNIFIED_CACHE_PACKET_TYPE_WIDTH,
    parameter int MASK_LEN      = `UNIFIED_CACHE_PACKET_BYTE_MASK_LEN,
    parameter int PORT_LEN      = `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH,
    parameter int PACKET_LEN    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic [NUM_REQUESTER*PACKET_LEN-1:0] request_packet_in,
    output logic [NUM_REQUESTER-1:0]            request_ack_out,
    output logic [PACKET_LEN-1:0]               issue_packet_out,
    input  logic                                issue_ack_in,
    output logic [$clog2(NUM_REQUESTER)-1:0]    grant_port_out
);

    localparam int PORT_POS  = ADDR_LEN + DATA_LEN + TYPE_LEN + MASK_LEN;
    localparam int VALID_POS = PORT_POS + PORT_LEN;
    localparam int GW        = $clog2(NUM_REQUESTER);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                   state;
    logic [GW-1:0]            rr_ptr;
    logic [NUM_REQUESTER-1:0] req;
    logic                     can_accept;
    logic                     any_req;
    logic [GW-1:0]            winner;
    logic [GW-1:0]            next_ptr;
    logic [PACKET_LEN-1:0]    winner_packet;
    logic [PACKET_LEN-1:0]    capture_packet;

    // Extract the valid bit of every port's packet.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            req[i] = request_packet_in[i*PACKET_LEN + VALID_POS];
        end
    end

    // Slot is free when empty, or when the held packet leaves this cycle.
    always_comb begin
        can_accept = (state == IDLE) || issue_ack_in;
    end

    // Round-robin scan from rr_ptr; scanning backwards so the earliest hit wins.
    always_comb begin
        int idx;
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int k = NUM_REQUESTER - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQUESTER;
            if (req[idx]) begin
                any_req = 1'b1;
                winner  = idx[GW-1:0];
            end
        end
    end

    // Pointer moves just past the winner, wrapping at the last port.
    always_comb begin
        if (winner == GW'(NUM_REQUESTER - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + 1'b1;
        end
    end

    // Mux out the winning port's packet.
    always_comb begin
        winner_packet = '0;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            if (winner == GW'(i)) begin
                winner_packet = request_packet_in[i*PACKET_LEN +: PACKET_LEN];
            end
        end
    end

`ifdef UNIFIED_CACHE_ARB_PORT_STAMP_EN
    // Overwrite the port id field with the zero-extended winner index.
    always_comb begin
        logic [PORT_LEN-1:0] stamp_id;
        stamp_id         = '0;
        stamp_id[GW-1:0] = winner;
        capture_packet   = winner_packet;
        capture_packet[PORT_POS +: PORT_LEN] = stamp_id;
    end
`else
    // Packet passes through bit-exact.
    always_comb begin
        capture_packet = winner_packet;
    end
`endif

    // One-hot acknowledge to the port being captured this cycle.
    always_comb begin
        request_ack_out = '0;
        if (!reset_in && can_accept && any_req) begin
            request_ack_out[winner] = 1'b1;
        end
    end

    // Slot FSM: capture on a free slot, drain to IDLE when nothing is pending.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant_port_out   <= '0;
            issue_packet_out <= '0;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (can_accept) begin
                        if (any_req) begin
                            state            <= HOLD;
                            issue_packet_out <= capture_packet;
                            grant_port_out   <= winner;
                            rr_ptr           <= next_ptr;
                        end else begin
                            state            <= IDLE;
                            issue_packet_out <= '0;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    issue_packet_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_cache_packet_arbiter.sv
// Directed bench for unified_cache_packet_arbiter.
// Stamp expectations follow UNIFIED_CACHE_ARB_PORT_STAMP_EN.

module tb_unified_cache_packet_arbiter;

    localparam int N    = 4;
    localparam int AL   = 32;
    localparam int DL   = 64;
    localparam int TL   = 4;
    localparam int ML   = 8;
    localparam int PLN  = 2;
    localparam int PP   = AL + DL + TL + ML;
    localparam int VP   = PP + PLN;
    localparam int PL   = VP + 1;

    logic              clk_in;
    logic              reset_in;
    logic [N*PL-1:0]   request_packet_in;
    logic [N-1:0]      request_ack_out;
    logic [PL-1:0]     issue_packet_out;
    logic              issue_ack_in;
    logic [1:0]        grant_port_out;

    int n_tests;
    int n_fail;

    logic [PL-1:0] pk [N];
    logic [PL-1:0] pk3z;
    logic [PL-1:0] exp_stamp;

    unified_cache_packet_arbiter #(
        .NUM_REQUESTER (N),
        .ADDR_LEN      (AL),
        .DATA_LEN      (DL),
        .TYPE_LEN      (TL),
        .MASK_LEN      (ML),
        .PORT_LEN      (PLN),
        .PACKET_LEN    (PL)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .request_packet_in (request_packet_in),
        .request_ack_out   (request_ack_out),
        .issue_packet_out  (issue_packet_out),
        .issue_ack_in      (issue_ack_in),
        .grant_port_out    (grant_port_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PL-1:0] mk(input int p, input logic [1:0] pid);
        logic [PL-1:0] r;
        r = '0;
        r[31:0]    = 32'h1000_0000 + 32'(p * 16);
        r[63:32]   = 32'hA5A5_0000 | 32'(p);
        r[95:64]   = 32'h5A5A_0000 | 32'(p);
        r[99:96]   = 4'(p + 1);
        r[107:100] = 8'hF0 | 8'(p);
        r[109:108] = pid;
        r[110]     = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] v);
        logic [PL-1:0] s;
        for (int i = 0; i < N; i++) begin
            s = pk[i];
            s[VP] = v[i];
            request_packet_in[i*PL +: PL] = s;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < N; i++) pk[i] = mk(i, 2'(i));
        pk3z = mk(3, 2'd0);
        exp_stamp = pk3z;
`ifdef UNIFIED_CACHE_ARB_PORT_STAMP_EN
        exp_stamp[PP +: PLN] = 2'd3;
`endif

        reset_in     = 1'b1;
        issue_ack_in = 1'b0;
        drive(4'b1111);
        #1;
        check("rst_ack", 128'(request_ack_out), 128'h0);
        tick();
        tick();
        check("rst_ack2", 128'(request_ack_out), 128'h0);
        check("rst_valid", 128'(issue_packet_out[VP]), 128'h0);
        check("rst_issue", 128'(issue_packet_out), 128'h0);
        check("rst_grant", 128'(grant_port_out), 128'h0);

        reset_in = 1'b0;
        #1;
        check("rel_ack0", 128'(request_ack_out), 128'h1);
        tick();
        check("rr_grant0", 128'(grant_port_out), 128'h0);
        check("rr_issue0", 128'(issue_packet_out), 128'(pk[0]));
        issue_ack_in = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("rr_ack", 128'(request_ack_out), 128'(4'b0001 << (c % 4)));
            tick();
            check("rr_grant", 128'(grant_port_out), 128'(c % 4));
            check("rr_issue", 128'(issue_packet_out), 128'(pk[c % 4]));
        end

        drive(4'b0100);
        #1;
        check("h_ack2", 128'(request_ack_out), 128'h4);
        tick();
        check("h_grant2", 128'(grant_port_out), 128'h2);
        issue_ack_in = 1'b0;
        drive(4'b1111);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("h_noack", 128'(request_ack_out), 128'h0);
            tick();
            check("h_grant", 128'(grant_port_out), 128'h2);
            check("h_issue", 128'(issue_packet_out), 128'(pk[2]));
        end

        issue_ack_in = 1'b1;
        drive(4'b0010);
        #1;
        check("p_ack1", 128'(request_ack_out), 128'h2);
        tick();
        check("p_grant1", 128'(grant_port_out), 128'h1);
        drive(4'b1010);
        #1;
        check("p_ack3", 128'(request_ack_out), 128'h8);
        tick();
        check("p_grant3", 128'(grant_port_out), 128'h3);
        check("p_issue3", 128'(issue_packet_out), 128'(pk[3]));

        drive(4'b1000);
        request_packet_in[3*PL +: PL] = pk3z;
        #1;
        check("s_ack3", 128'(request_ack_out), 128'h8);
        tick();
        check("s_issue", 128'(issue_packet_out), 128'(exp_stamp));
        check("s_grant", 128'(grant_port_out), 128'h3);

        drive(4'b0000);
        #1;
        check("d_noack", 128'(request_ack_out), 128'h0);
        tick();
        check("d_valid", 128'(issue_packet_out[VP]), 128'h0);
        check("d_issue", 128'(issue_packet_out), 128'h0);
        check("d_grant", 128'(grant_port_out), 128'h3);
        tick();
        check("d_late", 128'(issue_packet_out), 128'h0);
        check("d_lgrant", 128'(grant_port_out), 128'h3);
        issue_ack_in = 1'b0;
        drive(4'b0001);
        #1;
        check("i_ack0", 128'(request_ack_out), 128'h1);
        tick();
        check("i_grant0", 128'(grant_port_out), 128'h0);
        check("i_issue0", 128'(issue_packet_out), 128'(pk[0]));

        drive(4'b1111);
        reset_in = 1'b1;
        #1;
        check("r_noack", 128'(request_ack_out), 128'h0);
        tick();
        check("r_issue", 128'(issue_packet_out), 128'h0);
        check("r_grant", 128'(grant_port_out), 128'h0);
        reset_in = 1'b0;
        #1;
        check("r_ack0", 128'(request_ack_out), 128'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
